// File: rtl/prog_loader_if.sv
// Program-transfer bus between prog_loader and its memories:
// boot ROM read port (address out, data back one cycle later) and the
// instruction-memory valid/ready write port.
interface prog_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_valid;
    logic              mem_ready;

    // Loader side: drives ROM address and the write request.
    modport master (
        output rom_addr,
        input  rom_data,
        output mem_addr,
        output mem_data,
        output mem_valid,
        input  mem_ready
    );

    // Memory side: returns ROM data and accepts writes.
    modport slave (
        input  rom_addr,
        output rom_data,
        input  mem_addr,
        input  mem_data,
        input  mem_valid,
        output mem_ready
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: copies ROM_DEPTH words from the boot ROM into the core's
// instruction memory after a synchronised start request, holding the core
// in reset for the whole transfer. Three cycles per word (FETCH, WAIT,
// WRITE) when the memory never stalls.
// Optional feature: define LOADER_CHECKSUM_EN to add a running checksum of
// accepted words and a compare against expected_sum.
module prog_loader #(
    parameter int ROM_DEPTH = 256,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    prog_loader_if.master     bus,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
`ifdef LOADER_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0] expected_sum,
    output logic [DATA_W-1:0] checksum,
    output logic              sum_ok
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Terminal index; idx stops here instead of wrapping, so this also
    // works when ROM_DEPTH fills the whole address space.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ROM_DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [2:0]        sync_q;
    logic              start_pulse;
    logic              accept;
    logic [ADDR_W-1:0] idx;

    // Two synchroniser stages plus one history stage for the edge detect.
    // NOTE: every register, synchroniser stages included, gets an explicit
    // async reset value so the block powers up quiet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], start};
        end
    end

    assign start_pulse = sync_q[1] & ~sync_q[2];

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept = (state_q == S_WRITE) && bus.mem_ready;

    // Next-state logic; start_pulse is only honoured in IDLE.
    // NOTE: state_d is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_pulse) state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: if (accept) state_d = (idx == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs decode straight from the state register, so an async
    // reset drops them at once without waiting for a clock edge.
    assign bus.mem_valid = (state_q == S_WRITE);
    assign busy          = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                           (state_q == S_WRITE);
    assign core_hold     = busy;
    assign bus.rom_addr  = idx;

    // Datapath: word index, captured write beat, counters and sticky done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            words_loaded <= '0;
            done         <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_pulse) begin
                        idx          <= '0;
                        words_loaded <= '0;
                        done         <= 1'b0;
                    end
                end
                S_WAIT: begin
                    bus.mem_data <= bus.rom_data;
                    bus.mem_addr <= idx;
                end
                S_WRITE: begin
                    if (accept) begin
                        words_loaded <= words_loaded + (ADDR_W+1)'(1);
                        if (idx == LAST_IDX) begin
                            done <= 1'b1;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of accepted words; compared against expected_sum in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
            sum_ok   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start_pulse) begin
                checksum <= '0;
                sum_ok   <= 1'b0;
            end else if (accept) begin
                checksum <= checksum + bus.mem_data;
            end else if (state_q == S_DONE) begin
                sum_ok <= (checksum == expected_sum);
            end
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: reset, full load, backpressure,
// start activity while busy, back-to-back loads, mid-transfer reset and
// (when LOADER_CHECKSUM_EN is defined) the checksum compare.
module tb_prog_loader;

    localparam int ROM_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_loaded;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] expected_sum;
    logic [DATA_W-1:0] checksum;
    logic              sum_ok;
`endif

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(.ROM_DEPTH(ROM_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
`ifdef LOADER_CHECKSUM_EN
        ,
        .expected_sum (expected_sum),
        .checksum     (checksum),
        .sum_ok       (sum_ok)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous boot ROM model: data valid one cycle after the address.
    logic [DATA_W-1:0] rom [ROM_DEPTH];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int checks = 0;
    int errors = 0;

    // Write log and per-run measurements filled in by run_load.
    logic [ADDR_W-1:0] wr_addr [ROM_DEPTH+8];
    logic [DATA_W-1:0] wr_data [ROM_DEPTH+8];
    int                wr_n;
    int                first_valid;
    int                done_cyc;
    int                stall_seen;
    int                stall_bad;
    logic              done_c2;
    logic              done_c3;
    bit                aborted;
    logic [3:0]        ab_ctrl;
    logic [ADDR_W:0]   ab_wl;

    // Drive one transfer. Inputs change and outputs are sampled on the
    // falling edge. Optional: stall word stall_word for stall_len cycles,
    // toggle start mid-transfer, or assert reset while word abort_word is
    // being offered.
    task automatic run_load(input int stall_word, input int stall_len,
                            input bit toggle, input int abort_word);
        int cyc;
        int stall_cnt;
        bus.mem_ready = 1'b1;
        start         = 1'b0;
        repeat (4) @(negedge clk);
        wr_n = 0; first_valid = -1; done_cyc = -1;
        stall_seen = 0; stall_bad = 0; aborted = 1'b0;
        done_c2 = 1'bx; done_c3 = 1'bx;
        cyc = 0; stall_cnt = 0;
        start = 1'b1;
        while (cyc < 3000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) done_c2 = done;
            if (cyc == 3) done_c3 = done;
            if (toggle && cyc >= 100 && cyc <= 150 && (cyc % 10) == 0)
                start = ~start;
            if (bus.mem_valid && first_valid < 0) first_valid = cyc;
            if (abort_word >= 0 && bus.mem_valid && int'(bus.mem_addr) == abort_word) begin
                reset = 1'b1;
                #1;
                ab_ctrl = {bus.mem_valid, busy, core_hold, done};
                ab_wl   = words_loaded;
                aborted = 1'b1;
                return;
            end
            bus.mem_ready = 1'b1;
            if (stall_word >= 0 && bus.mem_valid && int'(bus.mem_addr) == stall_word
                && stall_cnt < stall_len) begin
                bus.mem_ready = 1'b0;
                stall_cnt++;
                stall_seen++;
                if (bus.mem_data !== rom[stall_word]) stall_bad++;
            end
            if (bus.mem_valid && bus.mem_ready && wr_n < ROM_DEPTH + 8) begin
                wr_addr[wr_n] = bus.mem_addr;
                wr_data[wr_n] = bus.mem_data;
                wr_n++;
            end
            if (cyc > 3 && done) done_cyc = cyc;
        end
    endtask

    // Count log entries that differ from the ROM image in order.
    function automatic int log_errors();
        int bad = 0;
        for (int i = 0; i < ROM_DEPTH; i++)
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== rom[i]) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bus.mem_ready = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        expected_sum = '0;
`endif
        #30;
        checks++;
        if ({bus.rom_addr, bus.mem_addr, bus.mem_data, bus.mem_valid, core_hold,
             busy, done, words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_during: outputs not all zero (busy=%b valid=%b done=%b wl=%0d)",
                     busy, bus.mem_valid, done, words_loaded);
        end
        #70;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if ({bus.rom_addr, bus.mem_addr, bus.mem_data, bus.mem_valid, core_hold,
             busy, done, words_loaded} !== '0) begin
            errors++;
            $display("FAIL reset_after: outputs not all zero (busy=%b valid=%b done=%b wl=%0d)",
                     busy, bus.mem_valid, done, words_loaded);
        end
    endtask

    task automatic test_full_load();
        int bad;
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 32'hA500_0000 + i;
        run_load(-1, 0, 1'b0, -1);
        checks++;
        if (first_valid !== 5) begin
            errors++; $display("FAIL first_valid_latency: got %0d expected 5", first_valid);
        end
        checks++;
        if (done_cyc !== 771) begin
            errors++; $display("FAIL done_cycle: got %0d expected 771", done_cyc);
        end
        checks++;
        if (core_hold !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_release: core_hold=%b busy=%b expected 0 0", core_hold, busy);
        end
        checks++;
        if (words_loaded !== 9'd256) begin
            errors++; $display("FAIL words_loaded: got %0d expected 256", words_loaded);
        end
        checks++;
        if (wr_n !== 256) begin
            errors++; $display("FAIL write_count: got %0d expected 256", wr_n);
        end
        bad = log_errors();
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL write_contents: %0d bad entries expected 0", bad);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        run_load(10, 7, 1'b0, -1);
        checks++;
        if (done_cyc !== 778) begin
            errors++; $display("FAIL stall_done_cycle: got %0d expected 778", done_cyc);
        end
        checks++;
        if (stall_seen !== 7 || stall_bad !== 0) begin
            errors++; $display("FAIL stall_hold: stalled=%0d unstable=%0d expected 7 0", stall_seen, stall_bad);
        end
        checks++;
        if (wr_n !== 256) begin
            errors++; $display("FAIL stall_write_count: got %0d expected 256", wr_n);
        end
        bad = log_errors();
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL stall_contents: %0d bad entries expected 0", bad);
        end
    endtask

    task automatic test_start_while_busy();
        int bad;
        run_load(-1, 0, 1'b1, -1);
        checks++;
        if (wr_n !== 256 || done_cyc !== 771) begin
            errors++; $display("FAIL busy_restart: writes=%0d done_cyc=%0d expected 256 771", wr_n, done_cyc);
        end
        bad = log_errors();
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL busy_contents: %0d bad entries expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        run_load(-1, 0, 1'b0, -1);
        checks++;
        if (done_c2 !== 1'b1 || done_c3 !== 1'b0) begin
            errors++; $display("FAIL done_clear: cyc2=%b cyc3=%b expected 1 0", done_c2, done_c3);
        end
        checks++;
        if (wr_n !== 256 || done_cyc !== 771) begin
            errors++; $display("FAIL second_load: writes=%0d done_cyc=%0d expected 256 771", wr_n, done_cyc);
        end
        checks++;
        if (words_loaded !== 9'd256) begin
            errors++; $display("FAIL second_words: got %0d expected 256", words_loaded);
        end
    endtask

    task automatic test_reset_mid();
        run_load(-1, 0, 1'b0, 100);
        checks++;
        if (aborted !== 1'b1) begin
            errors++; $display("FAIL abort_reached: got %b expected 1", aborted);
        end
        checks++;
        if (ab_ctrl !== 4'b0000) begin
            errors++; $display("FAIL abort_async: valid/busy/hold/done=%b expected 0000", ab_ctrl);
        end
        checks++;
        if (ab_wl !== '0) begin
            errors++; $display("FAIL abort_words: got %0d expected 0", ab_wl);
        end
        checks++;
        if (wr_n !== 100) begin
            errors++; $display("FAIL abort_partial: got %0d writes expected 100", wr_n);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < ROM_DEPTH; i++) rom[i] = i + 1;
        expected_sum = 32'd32896;
        run_load(-1, 0, 1'b0, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (checksum !== 32'd32896 || sum_ok !== 1'b1) begin
            errors++; $display("FAIL checksum_match: sum=%0d ok=%b expected 32896 1", checksum, sum_ok);
        end
        expected_sum = 32'd0;
        run_load(-1, 0, 1'b0, -1);
        repeat (3) @(negedge clk);
        checks++;
        if (checksum !== 32'd32896 || sum_ok !== 1'b0) begin
            errors++; $display("FAIL checksum_mismatch: sum=%0d ok=%b expected 32896 0", checksum, sum_ok);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Target (writer) end of the program-transfer interface started by BTN[1] on the Arty S7 top.
- On a start request it copies ROM_DEPTH words from the boot ROM into the mest_pro instruction memory through a valid/ready write port.
- The core is held in reset for the whole transfer.
- Sits between the button conditioning in asic_top and the mest_pro core memory/reset inputs.

Parameters:
- ROM_DEPTH, 256, number of words transferred; must be at least 2.
- ADDR_W, 8, address width; requires ROM_DEPTH <= 2^ADDR_W.
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  raw program-transfer request (BTN[1] level); asynchronous to clk.
- rom_addr  output  ADDR_W  boot ROM read address.
- rom_data  input  DATA_W  boot ROM read data; valid one cycle after rom_addr.
- mem_addr  output  ADDR_W  instruction memory write address.
- mem_data  output  DATA_W  instruction memory write data.
- mem_valid  output  1  write request.
- mem_ready  input  1  memory accepts the write when mem_valid and mem_ready are both 1.
- core_hold  output  1  holds mest_pro in reset while 1.
- busy  output  1  transfer in progress.
- done  output  1  last transfer completed successfully; sticky.
- words_loaded  output  ADDR_W+1  count of accepted writes.

Behaviour:
- Reset (async, active-high) forces all outputs to 0 immediately:
  - rom_addr, mem_addr, mem_data, mem_valid, core_hold, busy, done, words_loaded = 0.
  - FSM = IDLE; synchronizer flops = 0.
- Start detection:
  - start passes through a 2-FF synchronizer, then a rising-edge detect.
  - start_pulse is high for 1 cycle, in the 3rd clk edge after start rises.
  - A held-high level produces exactly one pulse.
- IDLE:
  - Waits for start_pulse.
  - On start_pulse: idx=0, words_loaded=0, done=0, busy=1, core_hold=1, go to FETCH.
- FETCH: rom_addr=idx; go to WAIT.
- WAIT: rom_data is valid this cycle; register mem_data<=rom_data and mem_addr<=idx; go to WRITE.
- WRITE:
  - mem_valid=1; mem_addr and mem_data stay stable until accepted.
  - On mem_valid && mem_ready:
    - mem_valid drops next cycle and words_loaded increments.
    - If idx==ROM_DEPTH-1, go to DONE; otherwise idx+1 and go to FETCH.
  - mem_ready low stalls indefinitely with no timeout.
- DONE, for one cycle:
  - busy=0, core_hold=0, done=1; go to IDLE.
  - done stays 1 until the next start_pulse or reset.
- Throughput: 3 cycles per word when mem_ready is always 1. Entry to FETCH through entry to DONE takes 3*ROM_DEPTH cycles (768 at default).
- Last-word boundary: idx never wraps; ROM_DEPTH-1 is the terminal index even when ROM_DEPTH = 2^ADDR_W.
- words_loaded is ADDR_W+1 bits, so it reaches ROM_DEPTH without overflow.
- start_pulse while busy is ignored; no restart and no queuing.
- start_pulse in DONE is ignored. A new transfer needs start to fall and rise again while in IDLE.
- Reset mid-transfer aborts immediately:
  - mem_valid drops asynchronously; the partial image is left in memory.
  - done=0 and core_hold=0.
- mem_ready asserted outside WRITE has no effect.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum (DATA_W), a modulo-2^DATA_W sum of all accepted mem_data words.
  - checksum is cleared on start_pulse and on reset, and updated in the cycle after each accepted write.
  - Adds input expected_sum (DATA_W) and output sum_ok (1).
  - sum_ok is set in DONE if checksum equals expected_sum, and cleared on start_pulse and on reset.
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- Reset during idle:
  - Stimulus: reset=1 for 100 ns, then released.
  - Required: all outputs 0 during and after reset; FSM stays in IDLE with start=0.
- Full load, mem_ready tied 1:
  - Stimulus: ROM word i = 32'hA5000000+i; start raised and held.
  - Required: first mem_valid 5 cycles after start rises (2 synchronizer + 1 edge + FETCH + WAIT).
  - Required: 256 writes with mem_addr=i and mem_data=A5000000+i.
  - Required: done=1 and core_hold=0 at 768 cycles after FETCH entry; words_loaded=256.
- Backpressure:
  - Stimulus: mem_ready low for 7 cycles on word 10.
  - Required: mem_addr=10 and mem_data stable for all stalled cycles; no duplicated or skipped write; total cycles increase by 7.
- Start held or pulsed while busy:
  - Stimulus: start toggled 3 times mid-transfer.
  - Required: no restart; exactly 256 writes.
  - Stimulus: start falls then rises after done.
  - Required: second full load; done clears on the new start_pulse.
- Reset mid-operation:
  - Stimulus: reset asserted at word 100 while mem_valid=1.
  - Required: mem_valid, busy, core_hold and done fall to 0 without a clock edge; words_loaded=0.
- With LOADER_CHECKSUM_EN:
  - Stimulus: ROM words 1..256, expected_sum=32'd32896.
  - Required: checksum=32896 and sum_ok=1 at done.
  - Stimulus: expected_sum=0.
  - Required: sum_ok=0.
